// File: rtl/mult_sequencer.sv
// Control FSM for the shift-add signed multiplier: Run edge -> clear A/X, then WIDTH add/shift steps.
// Optional MULT_SEQ_SYNC_EN: 2-flop synchronizers on Run and ClearA_LoadB.
module mult_sequencer #(
  parameter int WIDTH = 8,
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Run,
  input  logic          ClearA_LoadB,
  input  logic          M,
  output logic          Clr_Ld,
  output logic          ClearA,
  output logic          Add,
  output logic          Sub,
  output logic          Shift,
  output logic          Busy,
  output logic          Done,
  output logic [IW-1:0] Iter,
  output logic [2:0]    fsm_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLRA  = 3'd1,
    S_ADD   = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

  state_t        state;
  state_t        state_nx;
  logic [IW-1:0] iter_nx;
  logic          run_use;
  logic          cl_use;
  logic          run_q;
  logic          run_edge;
  logic          last;

`ifdef MULT_SEQ_SYNC_EN
  // Run synchronizer resets high so a Run held through reset never looks like an edge.
  logic [1:0] run_sync;
  logic [1:0] cl_sync;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      run_sync <= 2'b11;
      cl_sync  <= 2'b00;
    end else begin
      run_sync <= {run_sync[0], Run};
      cl_sync  <= {cl_sync[0], ClearA_LoadB};
    end
  end

  assign run_use = run_sync[1];
  assign cl_use  = cl_sync[1];
`else
  assign run_use = Run;
  assign cl_use  = ClearA_LoadB;
`endif

  assign run_edge  = run_use && !run_q;
  assign last      = (Iter == LAST);
  assign fsm_state = state;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= S_IDLE;
      Iter  <= '0;
      run_q <= 1'b1;
    end else begin
      state <= state_nx;
      Iter  <= iter_nx;
      run_q <= run_use;
    end
  end

  always_comb begin
    state_nx = state;
    iter_nx  = Iter;
    Clr_Ld   = 1'b0;
    ClearA   = 1'b0;
    Add      = 1'b0;
    Sub      = 1'b0;
    Shift    = 1'b0;
    Busy     = 1'b0;
    Done     = 1'b0;
    case (state)
      S_IDLE: begin
        // A load request wins; a simultaneous Run edge is dropped, not queued.
        Clr_Ld  = cl_use;
        iter_nx = '0;
        if (!cl_use && run_edge) state_nx = S_CLRA;
      end
      S_CLRA: begin
        ClearA   = 1'b1;
        Busy     = 1'b1;
        iter_nx  = '0;
        state_nx = S_ADD;
      end
      S_ADD: begin
        Busy = 1'b1;
        if (M) begin
          if (last) Sub = 1'b1;
          else      Add = 1'b1;
        end
        state_nx = S_SHIFT;
      end
      S_SHIFT: begin
        Shift = 1'b1;
        Busy  = 1'b1;
        if (last) begin
          state_nx = S_DONE;
        end else begin
          iter_nx  = Iter + IW'(1);
          state_nx = S_ADD;
        end
      end
      S_DONE: begin
        Done = 1'b1;
        if (!run_use) begin
          state_nx = S_IDLE;
          iter_nx  = '0;
        end
      end
      default: begin
        state_nx = S_IDLE;
        iter_nx  = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_mult_sequencer.sv
// Directed bench for mult_sequencer (WIDTH=8); honours MULT_SEQ_SYNC_EN for the added input latency.
module tb_mult_sequencer;

  localparam int WIDTH = 8;
  localparam int IW = 3;
`ifdef MULT_SEQ_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic          Clk;
  logic          Reset;
  logic          Run;
  logic          ClearA_LoadB;
  logic          M;
  logic          Clr_Ld;
  logic          ClearA;
  logic          Add;
  logic          Sub;
  logic          Shift;
  logic          Busy;
  logic          Done;
  logic [IW-1:0] Iter;
  logic [2:0]    fsm_state;

  int checks = 0;
  int errors = 0;

  mult_sequencer #(.WIDTH(WIDTH)) dut (
    .Clk(Clk), .Reset(Reset), .Run(Run), .ClearA_LoadB(ClearA_LoadB), .M(M),
    .Clr_Ld(Clr_Ld), .ClearA(ClearA), .Add(Add), .Sub(Sub), .Shift(Shift),
    .Busy(Busy), .Done(Done), .Iter(Iter), .fsm_state(fsm_state)
  );

  // clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Drive a Run edge and walk the operation up to the first Done sample.
  task automatic run_op(input logic m);
    int add_n, sub_n, shf_n, clr_n, busy_n, excl_n, done_idx, clr_idx, sub_iter, clr_iter;
    add_n = 0; sub_n = 0; shf_n = 0; clr_n = 0; busy_n = 0; excl_n = 0;
    done_idx = -1; clr_idx = -1; sub_iter = 99; clr_iter = 99;
    M = m;
    Run = 1'b1;
    tick();
    for (int i = 0; i < 40; i++) begin
      if (Done) begin
        done_idx = i;
        break;
      end
      if (ClearA && clr_idx < 0) begin
        clr_idx  = i;
        clr_iter = int'(Iter);
      end
      if (Sub) sub_iter = int'(Iter);
      add_n  += int'(Add);
      sub_n  += int'(Sub);
      shf_n  += int'(Shift);
      clr_n  += int'(ClearA);
      busy_n += int'(Busy);
      if (int'(Clr_Ld) + int'(ClearA) + int'(Add) + int'(Sub) + int'(Shift) > 1) excl_n++;
      tick();
    end
    check_eq("done_latency", done_idx, LAT + 1 + 2 * WIDTH);
    check_eq("cleara_index", clr_idx, LAT);
    check_eq("cleara_iter", clr_iter, 0);
    check_eq("cleara_count", clr_n, 1);
    check_eq("busy_count", busy_n, 1 + 2 * WIDTH);
    check_eq("add_count", add_n, m ? WIDTH - 1 : 0);
    check_eq("sub_count", sub_n, m ? 1 : 0);
    check_eq("sub_iter", sub_iter, m ? WIDTH - 1 : 99);
    check_eq("shift_count", shf_n, WIDTH);
    check_eq("exclusive", excl_n, 0);
    check_eq("done_iter", Iter, WIDTH - 1);
  endtask

  // Hold Run through Done, then release and return to IDLE.
  task automatic finish_op();
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("done_hold", Done, 1);
      check_eq("done_busy", Busy, 0);
    end
    Run = 1'b0;
    for (int i = 0; i <= LAT; i++) begin
      tick();
      check_eq("done_release", Done, (i == LAT) ? 0 : 1);
    end
    check_eq("idle_iter", Iter, 0);
    check_eq("idle_state", fsm_state, 0);
  endtask

  initial begin
    int clr_cnt, busy_cnt, clr_first;
    Reset = 1'b0;
    Run = 1'b0;
    ClearA_LoadB = 1'b0;
    M = 1'b0;
    tick();
    tick();
    check_eq("reset_outputs", {Clr_Ld, ClearA, Add, Sub, Shift, Busy, Done, Iter}, 0);
    check_eq("reset_state", fsm_state, 0);
    Reset = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check_eq("idle_busy", Busy, 0);

    // M=1 throughout: 7 adds, a final subtract, 8 shifts
    run_op(1'b1);
    finish_op();
    // M=0 throughout, restart from Iter=0
    run_op(1'b0);
    finish_op();

    // ClearA_LoadB for 3 cycles with a simultaneous Run edge
    clr_cnt = 0;
    busy_cnt = 0;
    clr_first = -1;
    ClearA_LoadB = 1'b1;
    Run = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) ClearA_LoadB = 1'b0;
      #1;
      if (Clr_Ld && clr_first < 0) clr_first = i;
      clr_cnt  += int'(Clr_Ld);
      busy_cnt += int'(Busy);
      tick();
    end
    check_eq("clrld_count", clr_cnt, 3);
    check_eq("clrld_first", clr_first, LAT);
    check_eq("clrld_no_start", busy_cnt, 0);
    check_eq("clrld_state", fsm_state, 0);
    Run = 1'b0;
    for (int i = 0; i < LAT + 2; i++) tick();

    // Reset during ADD at Iter=4
    M = 1'b1;
    Run = 1'b1;
    tick();
    for (int i = 0; i < LAT + 9; i++) tick();
    check_eq("mid_state", fsm_state, 2);
    check_eq("mid_iter", Iter, 4);
    check_eq("mid_add", Add, 1);
    Reset = 1'b0;
    #1;
    check_eq("mid_reset_outputs", {Clr_Ld, ClearA, Add, Sub, Shift, Busy, Done, Iter}, 0);
    check_eq("mid_reset_state", fsm_state, 0);
    tick();
    tick();
    Reset = 1'b1;
    busy_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      busy_cnt += int'(Busy);
    end
    check_eq("post_reset_no_start", busy_cnt, 0);
    Run = 1'b0;
    for (int i = 0; i < LAT + 2; i++) tick();
    run_op(1'b1);
    finish_op();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_sequencer.md
Name: mult_sequencer

Overview:
Control FSM that sequences the 8-bit shift-add signed multiplier datapath (register A, register B, 9-bit adder, sign flop X). It detects a Run press and steps the datapath through one clear cycle and WIDTH add/shift iterations. On the final iteration it issues a subtract instead of an add. It also serves clear/load requests while idle and reports Busy/Done status to the top level.

Parameters:
WIDTH, 8, number of multiplier bits and add/shift iterations; legal range 2..32.

Ports:
Clk  input  1  system clock, rising-edge.
Reset  input  1  asynchronous, active-low reset.
Run  input  1  start request, level; the operation begins on its rising edge.
ClearA_LoadB  input  1  idle-time request to clear A/X and load B from the switches, level.
M  input  1  current LSB of register B (multiplier bit under test).
Clr_Ld  output  1  clear A/X and load B.
ClearA  output  1  clear A and X only; B is untouched.
Add  output  1  load adder sum into A (plus operation).
Sub  output  1  load adder sum into A (minus operation, final iteration).
Shift  output  1  arithmetic shift of the X:A:B chain by one bit.
Busy  output  1  high while an operation is in progress.
Done  output  1  high while the result is held.
Iter  output  $clog2(WIDTH)  index of the current iteration.

Behaviour:
- States: IDLE, CLRA, ADD, SHIFT, DONE. Outputs are decoded from the registered state. Add and Sub are additionally gated by M.
- Reset low (async): state=IDLE, Iter=0, run_q=1, all outputs 0. run_q resets to 1 so that Run held high through reset release does not start an operation.
- run_q <= Run every cycle. A rising edge is defined as Run=1 && run_q=0.
- IDLE:
  - Clr_Ld = ClearA_LoadB, combinational level, for as long as the request is held.
  - If ClearA_LoadB=1, stay in IDLE. A Run edge in the same cycle is dropped, not queued.
  - Else on a Run edge -> CLRA.
- CLRA: ClearA=1 for one cycle; Iter<=0; -> ADD.
- ADD (one cycle, always visited):
  - If M=1 and Iter<WIDTH-1: Add=1.
  - If M=1 and Iter==WIDTH-1: Sub=1.
  - If M=0: no load.
  - Then -> SHIFT.
- SHIFT: Shift=1 for one cycle.
  - If Iter==WIDTH-1 -> DONE.
  - Else Iter<=Iter+1 and -> ADD.
- DONE: Done=1. Stay until Run=0, then -> IDLE. Iter holds at WIDTH-1 in DONE; it is cleared on IDLE entry.
- Busy=1 in CLRA, ADD and SHIFT; 0 in IDLE and DONE.
- Mutual exclusion: at most one of Clr_Ld, ClearA, Add, Sub, Shift is high in any cycle. Add and Sub are never both high.
- Latency: with the Run edge sampled at clock edge E0, the first ClearA cycle is E0..E1 and Done rises at E0+1+2*WIDTH (E17 for WIDTH=8).
- Requests during an operation:
  - ClearA_LoadB in CLRA, ADD, SHIFT or DONE is ignored.
  - Run toggling during an operation has no effect.
  - A Run edge in DONE is impossible, since DONE is only left on Run=0.
- Reset mid-operation: immediate return to IDLE with outputs 0. The partial product in the datapath is left as-is.

Optional Feature:
MULT_SEQ_SYNC_EN:
- Defined: Run and ClearA_LoadB each pass through a 2-flop synchronizer before any use.
  - Synchronizer flops reset to 0 for ClearA_LoadB and to 1 for Run.
  - Edge detection and all request latencies grow by 2 cycles; Done rises at E0+3+2*WIDTH, measured from the first edge at which raw Run=1.
- Undefined: inputs are used directly, with no added latency.

Test Plan:
1. WIDTH=8, M=1 every cycle, Run pulse held high -> 1 ClearA, 7 Add, 1 Sub (Iter=7), 8 Shift; Done rises 17 clocks after the Run edge; Busy high for 17 cycles.
2. M=0 every cycle -> Add and Sub never assert; 8 Shift pulses; Done timing identical to scenario 1.
3. ClearA_LoadB held 3 cycles in IDLE -> Clr_Ld high for exactly those 3 cycles. A Run edge raised in the same cycle does not start an operation; Busy stays 0.
4. Run held high through Done, then released -> Done stays 1 until the cycle after Run=0, then IDLE. A new Run edge restarts with Iter=0.
5. Reset asserted during ADD at Iter=4 -> all outputs 0 immediately. After release with Run still high: no start until Run falls and rises again.
6. With MULT_SEQ_SYNC_EN defined, repeat scenario 1 -> Done rises 19 clocks after the first edge sampling raw Run=1.
